// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-path definitions: word width, default ack timeout and
// the memory-controller state encoding.
`timescale 1ns/1ps
package lc3_pkg;

  localparam int WORD_W              = 16;
  localparam int DEF_TIMEOUT_CYCLES  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_timeout.sv
// Ack wait counter for the LC-3 memory controller: cleared while the request
// is on the bus, counts wait cycles and flags expiry on the last allowed one.
`timescale 1ns/1ps
module lc3_mem_timeout #(
  parameter int TIMEOUT_CYCLES = lc3_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Expiry fires in the final wait cycle so DONE follows on the next edge.
  assign o_expired = i_inc && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR and single-outstanding memory handshake; returns R to control.
// Optional ack timeout with sticky mem_err under `LC3_MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int ADDR_W         = WORD_W,
  parameter int DATA_W         = WORD_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [DATA_W-1:0] bus_in,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              R,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;

  logic              w_busy;
  logic              w_ack_in_flight;
  logic              w_rd_done;
  logic              w_start;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_mar_next;
  logic [DATA_W-1:0] w_mdr_next;

  assign w_busy          = (r_state == REQ) || (r_state == WAIT);
  assign w_ack_in_flight = w_busy && mem_ack;
  assign w_rd_done       = w_ack_in_flight && !r_we;
  assign w_start         = (w_next == REQ);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (MIO_EN) w_next = REQ;
      REQ:  w_next = mem_ack ? DONE : WAIT;
      WAIT: if (mem_ack || w_timeout) w_next = DONE;
      DONE: w_next = MIO_EN ? REQ : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A completed read owns MDR even if the bus path asks to load it the same cycle.
  always_comb begin
    w_mar_next = LD_MAR ? bus_in[ADDR_W-1:0] : r_mar;
    w_mdr_next = r_mdr;
    if (w_rd_done) begin
      w_mdr_next = mem_rdata;
    end else if (LD_MDR && !MIO_EN) begin
      w_mdr_next = bus_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mar        <= '0;
      r_mdr        <= '0;
      r_we         <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_state <= w_next;
      r_mar   <= w_mar_next;
      r_mdr   <= w_mdr_next;
      if (w_start) begin
        r_we         <= R_W;
        r_addr_hold  <= w_mar_next;
        r_wdata_hold <= w_mdr_next;
      end else if (w_next == DONE) begin
        r_we <= 1'b0;
      end
    end
  end

`ifdef LC3_MEM_TIMEOUT_EN
  logic r_err;

  lc3_mem_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state == REQ),
    .i_inc     (r_state == WAIT),
    .o_expired (w_timeout)
  );

  // An ack in the expiry cycle wins; the error is only for a true no-show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_timeout && !mem_ack) begin
      r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  assign MAR       = r_mar;
  assign MDR       = r_mdr;
  assign R         = (r_state == DONE);
  assign mem_req   = (r_state == REQ);
  assign mem_we    = r_we;
  // Memory sees the request-time copies while the access is in flight.
  assign mem_addr  = w_busy ? r_addr_hold  : r_mar;
  assign mem_wdata = w_busy ? r_wdata_hold : r_mdr;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed scoreboard bench for lc3_mem_ctrl: stimulus pushes the expected R
// completion, a negedge monitor pops and checks each R pulse.
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;
  import lc3_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        LD_MAR = 1'b0, LD_MDR = 1'b0, MIO_EN = 1'b0, R_W = 1'b0;
  logic [15:0] bus_in = '0;
  logic [15:0] MAR, MDR, mem_addr, mem_wdata;
  logic        R, mem_req, mem_we, mem_err;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  lc3_mem_ctrl #(
    .ADDR_W (16), .DATA_W (16), .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .LD_MAR (LD_MAR), .LD_MDR (LD_MDR),
    .MIO_EN (MIO_EN), .R_W (R_W), .bus_in (bus_in), .MAR (MAR), .MDR (MDR),
    .R (R), .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_ack (mem_ack),
    .mem_err (mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] mdr;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   r_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every R pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && R === 1'b1) begin
        r_seen++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_R: got R=1 at cycle %0d expected no pulse", cyc);
        end else begin
          e = sb_q.pop_front();
          check("R_cycle", cyc, e.at);
          check("MDR_at_R", MDR, e.mdr);
          check("err_at_R", mem_err, e.err);
        end
      end
    end
  end

  task automatic load_mar(input logic [15:0] v);
    @(posedge clk); #1; LD_MAR = 1'b1; bus_in = v;
    @(posedge clk); #1; LD_MAR = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    @(posedge clk); #1; LD_MDR = 1'b1; MIO_EN = 1'b0; bus_in = v;
    @(posedge clk); #1; LD_MDR = 1'b0;
  endtask

  // delay < 0: ack in the REQ cycle; otherwise ack after 'delay' idle WAIT cycles.
  task automatic do_access(input logic rw, input int delay, input logic [15:0] rdata,
                           input logic [15:0] exp_mdr, input bit disturb);
    logic [15:0] a0, d0;
    int start;
    @(posedge clk); #1;
    MIO_EN = 1'b1; R_W = rw; start = cyc; a0 = MAR; d0 = MDR;
    sb_q.push_back('{mdr: exp_mdr, err: 1'b0, at: start + ((delay < 0) ? 2 : 3 + delay)});
    @(posedge clk); #1;
    check("req_asserted", mem_req, 1);
    check("req_addr", mem_addr, a0);
    check("req_we", mem_we, rw);
    if (rw) check("req_wdata", mem_wdata, d0);
    MIO_EN = 1'b0;
    if (delay < 0) begin
      mem_ack = 1'b1; mem_rdata = rdata;
    end else begin
      for (int w = 0; w < delay; w++) begin
        @(posedge clk); #1;
        if (w == 0) begin
          check("req_one_cycle", mem_req, 0);
          if (disturb) begin LD_MAR = 1'b1; bus_in = 16'h5555; end
        end
        if (w == 1 && disturb) begin
          LD_MAR = 1'b0;
          check("addr_held", mem_addr, a0);
          check("mar_updated", MAR, 16'h5555);
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = rdata;
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    check("we_cleared_done", mem_we, 0);
  endtask

  initial begin
    int start;
    int seen;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_MAR", MAR, 0);
    check("rst_MDR", MDR, 0);
    check("rst_R", R, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_err", mem_err, 0);

    // Zero-wait read
    load_mar(16'h3000);
    do_access(1'b0, 0, 16'h1234, 16'h1234, 1'b0);

    // Write with four wait cycles; read data must not land in MDR
    load_mar(16'h4000);
    load_mdr(16'hBEEF);
    do_access(1'b1, 4, 16'hDEAD, 16'hBEEF, 1'b0);

    // Ack in the REQ cycle
    load_mar(16'h0123);
    do_access(1'b0, -1, 16'hA5A5, 16'hA5A5, 1'b0);

    // MAR reload during WAIT after MIO_EN dropped
    load_mar(16'h3000);
    do_access(1'b0, 2, 16'h0F0F, 16'h0F0F, 1'b1);
    check("mar_after_disturb", MAR, 16'h5555);

    // Stray ack while idle is ignored
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk); #1; mem_ack = 1'b0;
    check("idle_ack_mdr", MDR, 16'h0F0F);
    check("idle_ack_R", R, 0);

    // Async reset in WAIT, then a late ack
    load_mar(16'h2222);
    @(posedge clk); #1; MIO_EN = 1'b1; R_W = 1'b0;
    @(posedge clk); #1; MIO_EN = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_mar", MAR, 16'h2222);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_R", R, 0);
    check("arst_MAR", MAR, 0);
    check("arst_MDR", MDR, 0);
    check("arst_addr", mem_addr, 0);
    seen = r_seen;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 16'h9999;
    @(posedge clk); #1; mem_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("no_R_after_rst", r_seen, seen);
    check("late_ack_mdr", MDR, 0);

    // Never-acked access
    load_mar(16'h6000);
    load_mdr(16'h7777);
    @(posedge clk); #1; MIO_EN = 1'b1; R_W = 1'b0; start = cyc;
`ifdef LC3_MEM_TIMEOUT_EN
    sb_q.push_back('{mdr: 16'h7777, err: 1'b1, at: start + 2 + TO});
    @(posedge clk); #1; MIO_EN = 1'b0;
    repeat (TO + 6) @(posedge clk);
    #1;
    check("err_sticky", mem_err, 1);
    check("timeout_mdr", MDR, 16'h7777);
    check("timeout_R_low", R, 0);
`else
    @(posedge clk); #1; MIO_EN = 1'b0;
    seen = r_seen;
    repeat (40) @(posedge clk);
    #1;
    check("wait_forever_R", r_seen, seen);
    check("wait_forever_req", mem_req, 0);
    check("wait_forever_err", mem_err, 0);
    check("wait_forever_mdr", MDR, 16'h7777);
    check("wait_forever_cyc", cyc - start, 41);
`endif

    @(posedge clk); #1;
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Consumer end of the effective-address path. Latches the address produced by the base-select/adder stage into MAR and the data into MDR.
- Runs a single-outstanding request/acknowledge transaction to memory and returns the LC-3 memory-ready signal R to the control FSM.
- Sits between the datapath bus and the unified instruction/data memory.

Parameters:
- ADDR_W, 16, address width (MAR width)
- DATA_W, 16, data width (MDR width)
- TIMEOUT_CYCLES, 255, ack wait limit when the timeout feature is compiled in

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- LD_MAR  in  1  load MAR from bus_in this cycle
- LD_MDR  in  1  load MDR this cycle (source per MIO_EN)
- MIO_EN  in  1  1 = memory access enabled; MDR loads from memory read data
- R_W  in  1  1 = write, 0 = read; sampled at request start
- bus_in  in  DATA_W  datapath bus (address for MAR, data for MDR when MIO_EN=0)
- MAR  out  ADDR_W  address register
- MDR  out  DATA_W  data register
- R  out  1  memory ready, single-cycle pulse on completion
- mem_req  out  1  request valid to memory
- mem_we  out  1  write strobe qualifier
- mem_addr  out  ADDR_W  equals MAR
- mem_wdata  out  DATA_W  equals MDR
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- mem_err  out  1  sticky timeout flag (0 unless the feature is enabled)

Behaviour:
- Reset (async, rst_n=0): MAR=0, MDR=0, R=0, mem_req=0, mem_we=0, mem_err=0; state=IDLE.
- Reset asserted mid-transaction aborts immediately. No R pulse is generated afterwards.
- MAR loads bus_in on the clock edge when LD_MAR=1, in any state.
- MDR with MIO_EN=0: loads bus_in on the edge when LD_MDR=1.
- MDR with MIO_EN=1: loads mem_rdata only on a completed read.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE -> REQ when MIO_EN=1. R_W is captured into mem_we.
- REQ: mem_req=1 for exactly one cycle, then -> WAIT. An ack arriving in the REQ cycle is honoured and goes directly to DONE.
- WAIT: mem_req=0. On mem_ack -> DONE. If the access was a read, MDR <= mem_rdata on the same edge.
- DONE: R=1 for one cycle; mem_we cleared.
  - If MIO_EN is still 1, a new access starts next cycle (-> REQ). This matches the FSM holding MIO_EN across back-to-back state pairs.
  - Otherwise -> IDLE.
- Latency from MIO_EN rising to R, with zero-wait memory (ack in the cycle after req): 3 cycles (REQ, WAIT, DONE).
- LD_MAR or LD_MDR (MIO_EN=0 path) while in REQ/WAIT: the registers update, but mem_addr/mem_wdata keep the values captured at REQ. Hold copies are registered internally.
- MIO_EN dropping during REQ/WAIT does not cancel the access. It completes and R still pulses.
- mem_ack in IDLE/DONE is ignored.
- No arithmetic; widths are exact, no truncation.

Optional Feature:
- Macro LC3_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter (sized from TIMEOUT_CYCLES) clears at REQ and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ack: -> DONE, R pulses, MDR unchanged, mem_err set.
  - mem_err stays set until reset.
- Undefined: no counter; WAIT holds indefinitely; mem_err tied 0.

Decomposition:
- Shared package lc3_pkg:
  - state encoding typedef mem_state_t (IDLE=0, REQ=1, WAIT=2, DONE=3)
  - WORD_W=16
  - default TIMEOUT_CYCLES
- One natural sub-module: lc3_mem_timeout (counter plus compare), instantiated only under LC3_MEM_TIMEOUT_EN.

Test Plan:
- Reset then idle: rst_n low then high, no stimulus -> MAR=0, MDR=0, R=0, mem_req=0.
- Read: LD_MAR with bus_in=0x3000; MIO_EN=1, R_W=0; memory acks 1 cycle after req with rdata=0x1234 -> mem_addr=0x3000, R pulses 3 cycles after MIO_EN, MDR=0x1234.
- Write: MAR=0x4000, LD_MDR with MIO_EN=0 and bus=0xBEEF; then MIO_EN=1, R_W=1, ack after 4 wait cycles -> mem_we=1, mem_wdata=0xBEEF, R after ack, MDR unchanged.
- Mid-access disturbance: during WAIT, LD_MAR with bus=0x5555 and MIO_EN dropped -> mem_addr stays the original address, access completes, R pulses, MAR=0x5555 afterwards.
- Async reset in WAIT: rst_n low between clock edges -> mem_req/R/MAR/MDR clear immediately; a later ack produces no R.
- With LC3_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, never ack -> R at cycle 8 of WAIT, mem_err=1 and sticky, MDR unchanged; without the macro R never asserts.
